// File: rtl/md_unit_if.sv
// Handshake bundle between the EX stage and the multiply/divide unit.
interface md_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [3:0]            md_op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  busy;
  logic                  stall_req;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, md_op, a, b,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
    input  start, md_op, a, b,
    output busy, stall_req, done, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave bus
);
  localparam int unsigned W         = DATA_WIDTH;
  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] MulCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;
`endif

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    hi_q, lo_q;
  logic            busy_q, done_q;
  logic [2*W-1:0]  res_q;
  logic            wr_q;
`ifdef MD_MADD_EN
  logic            acc_q, sub_q;
  logic            is_acc, is_sub;
`endif

  logic is_mul, is_div, is_signed, is_mthi, is_mtlo;

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
`ifdef MD_MADD_EN
    is_acc    = 1'b0;
    is_sub    = 1'b0;
`endif
    case (bus.md_op)
      OpMult:  begin is_mul = 1'b1; is_signed = 1'b1; end
      OpMultu: is_mul = 1'b1;
      OpDiv:   begin is_div = 1'b1; is_signed = 1'b1; end
      OpDivu:  is_div = 1'b1;
      OpMthi:  is_mthi = 1'b1;
      OpMtlo:  is_mtlo = 1'b1;
`ifdef MD_MADD_EN
      OpMadd:  begin is_mul = 1'b1; is_signed = 1'b1; is_acc = 1'b1; end
      OpMaddu: begin is_mul = 1'b1; is_acc = 1'b1; end
      OpMsub:  begin is_mul = 1'b1; is_signed = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
      OpMsubu: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Truncating a sign-extended 2W x 2W product to 2W bits gives the signed product.
  logic [2*W-1:0] ext_a, ext_b, prod;
  assign ext_a = is_signed ? {{W{bus.a[W-1]}}, bus.a} : {{W{1'b0}}, bus.a};
  assign ext_b = is_signed ? {{W{bus.b[W-1]}}, bus.b} : {{W{1'b0}}, bus.b};
  assign prod  = ext_a * ext_b;

  // Sign-magnitude divide; most-negative / -1 naturally wraps back to a with remainder 0.
  logic         neg_a, neg_b, div_zero;
  logic [W-1:0] mag_a, mag_b, divisor, mag_q, mag_r, quo, rem;
  assign neg_a    = is_signed & bus.a[W-1];
  assign neg_b    = is_signed & bus.b[W-1];
  assign mag_a    = neg_a ? -bus.a : bus.a;
  assign mag_b    = neg_b ? -bus.b : bus.b;
  assign div_zero = (bus.b == '0);
  assign divisor  = div_zero ? {{(W-1){1'b0}}, 1'b1} : mag_b;
  assign mag_q    = mag_a / divisor;
  assign mag_r    = mag_a % divisor;
  assign quo      = (neg_a ^ neg_b) ? -mag_q : mag_q;
  assign rem      = neg_a ? -mag_r : mag_r;

  logic [2*W-1:0] commit_val;
`ifdef MD_MADD_EN
  assign commit_val = !acc_q ? res_q :
                      sub_q  ? ({hi_q, lo_q} - res_q) : ({hi_q, lo_q} + res_q);
`else
  assign commit_val = res_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      wr_q    <= 1'b0;
`ifdef MD_MADD_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (is_mthi) hi_q <= bus.a;
            if (is_mtlo) lo_q <= bus.a;
            if (is_mul || is_div) begin
              res_q   <= is_div ? {rem, quo} : prod;
              wr_q    <= ~(is_div & div_zero);
`ifdef MD_MADD_EN
              acc_q   <= is_acc;
              sub_q   <= is_sub;
`endif
              cnt_q   <= is_div ? DivCnt : MulCnt;
              busy_q  <= 1'b1;
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            if (wr_q) {hi_q, lo_q} <= commit_val;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.stall_req = busy_q | (bus.start & (is_mul | is_div));
endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed expected values.
module tb_md_unit;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  md_unit_if #(.DATA_WIDTH(32)) bus ();

  md_unit #(
    .DATA_WIDTH (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds start for one rising edge, then scrambles operands.
  task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic exp_stall, input string tag);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = va;
    bus.b     = vb;
    #1;
    check({tag, " stall_req"}, 64'(bus.stall_req), 64'(exp_stall));
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = 4'd0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Counts busy cycles from now; returns at the cycle after the last busy one.
  task automatic run_busy(input string tag, input int exp_cycles);
    int n = 0;
    int early_done = 0;
    int no_stall = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      if (bus.done !== 1'b0) early_done++;
      if (bus.stall_req !== 1'b1) no_stall++;
      n++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, 64'(n), 64'(exp_cycles));
    check({tag, " done during busy"}, 64'(early_done), 64'd0);
    check({tag, " stall during busy"}, 64'(no_stall), 64'd0);
    check({tag, " done pulse"}, 64'(bus.done), 64'd1);
  endtask

  task automatic done_clears(input string tag);
    @(negedge clk);
    check({tag, " done cleared"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int seen_done;
    int seen_prod;
    bus.start = 1'b0;
    bus.md_op = 4'd0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset stall", 64'(bus.stall_req), 64'd0);

    issue(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b1, "mult");
    run_busy("mult", 5);
    check("mult hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    done_clears("mult");

    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, "multu");
    run_busy("multu", 5);
    check("multu hilo", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
    done_clears("multu");

    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, "div");
    run_busy("div", 10);
    check("div lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    check("div hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    done_clears("div");

    issue(4'd4, 32'd7, 32'd2, 1'b1, "divu");
    run_busy("divu", 10);
    check("divu lo", 64'(bus.lo), 64'd3);
    check("divu hi", 64'(bus.hi), 64'd1);
    done_clears("divu");

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div ovf");
    run_busy("div ovf", 10);
    check("div ovf hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    done_clears("div ovf");

    issue(4'd5, 32'h1234, 32'd0, 1'b0, "mthi");
    check("mthi hi", 64'(bus.hi), 64'h1234);
    check("mthi busy", 64'(bus.busy), 64'd0);
    check("mthi done", 64'(bus.done), 64'd0);
    issue(4'd6, 32'h5678, 32'd0, 1'b0, "mtlo");
    check("mtlo lo", 64'(bus.lo), 64'h5678);
    check("mtlo hi kept", 64'(bus.hi), 64'h1234);
    check("mtlo busy", 64'(bus.busy), 64'd0);
    check("mtlo done", 64'(bus.done), 64'd0);

    issue(4'd5, 32'hAA, 32'd0, 1'b0, "set hi");
    issue(4'd6, 32'hBB, 32'd0, 1'b0, "set lo");
    issue(4'd4, 32'd99, 32'd0, 1'b1, "divu0");
    run_busy("divu0", 10);
    check("divu0 hilo", {bus.hi, bus.lo}, 64'h0000_00AA_0000_00BB);
    done_clears("divu0");

    // MTLO issued in the first busy cycle must be ignored.
    issue(4'd1, 32'h10, 32'h20, 1'b1, "mult2");
    issue(4'd6, 32'h99, 32'd0, 1'b1, "mtlo in busy");
    run_busy("mult2", 4);
    check("mult2 hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_0200);
    done_clears("mult2");

    issue(4'd11, 32'h77, 32'h3, 1'b0, "undef op");
    check("undef busy", 64'(bus.busy), 64'd0);
    check("undef hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_0200);

    // Reset in the third busy cycle aborts the multiply.
    issue(4'd1, 32'd5, 32'd6, 1'b1, "mult rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort hilo", {bus.hi, bus.lo}, 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    seen_done = 0;
    seen_prod = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) seen_done++;
      if (bus.lo === 32'd30) seen_prod++;
    end
    check("abort late done", 64'(seen_done), 64'd0);
    check("abort late product", 64'(seen_prod), 64'd0);

    issue(4'd5, 32'd0, 32'd0, 1'b0, "acc hi");
    issue(4'd6, 32'd10, 32'd0, 1'b0, "acc lo");
`ifdef MD_MADD_EN
    issue(4'd7, 32'd2, 32'd3, 1'b1, "madd");
    run_busy("madd", 5);
    check("madd hilo", {bus.hi, bus.lo}, 64'd16);
    done_clears("madd");
    issue(4'd10, 32'd4, 32'd5, 1'b1, "msubu");
    run_busy("msubu", 5);
    check("msubu hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFC);
    done_clears("msubu");
`else
    issue(4'd7, 32'd2, 32'd3, 1'b0, "madd nop");
    check("madd nop busy", 64'(bus.busy), 64'd0);
    issue(4'd10, 32'd4, 32'd5, 1'b0, "msubu nop");
    @(negedge clk);
    check("madd nop busy2", 64'(bus.busy), 64'd0);
    check("madd nop done", 64'(bus.done), 64'd0);
    check("madd nop hilo", {bus.hi, bus.lo}, 64'd10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
